// File: rtl/controle_varredura.sv
// Scan controller for a two-digit 7-segment display: units/tens multiplexing with blanking gaps and a frame-aligned score update.
// Latency: first digit lit one cycle after habilita is sampled in IDLE; a new score shows at the next frame start (at most one frame + 1 cycle).
// Backpressure: none. atualiza is accepted every cycle (last strobe wins), and SUPRIME_ZERO_EN blanks a leading zero in the tens digit.
module controle_varredura #(
    parameter int DIVISOR = 50000,  // cycles each digit is lit
    parameter int BLANK   = 500     // cycles with all anodes off between digits
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       habilita,
    input  logic [7:0] placar,
    input  logic       atualiza,
    output logic [7:0] N,
    output logic       escolha,
    output logic [1:0] anodo,
    output logic       quadro
);

    localparam int MAXV = (DIVISOR > BLANK) ? ((DIVISOR > 2) ? DIVISOR : 2)
                                            : ((BLANK   > 2) ? BLANK   : 2);
    localparam int CW   = $clog2(MAXV);

    // Last count value of a lit slot and of a blanking slot
    localparam logic [CW-1:0] LAST_D = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] LAST_B = CW'(BLANK - 1);

    typedef enum logic [2:0] {
        IDLE,
        UNID,
        PAUSA_U,
        DEZ,
        PAUSA_D
    } estado_t;

    estado_t       r_estado;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_sombra;
    logic [7:0]    r_n;
    logic          r_escolha;
    logic [1:0]    r_anodo;
    logic          r_quadro;

    logic [7:0]    w_carga;
    logic [1:0]    w_anodo_dez;
    logic          w_fim_div;
    logic          w_fim_blk;

    // A strobe in the same cycle as a frame entry bypasses the shadow register
    assign w_carga   = atualiza ? placar : r_sombra;
    assign w_fim_div = (r_cnt == LAST_D);
    assign w_fim_blk = (r_cnt == LAST_B);

`ifdef SUPRIME_ZERO_EN
    // Leading zero in the tens digit keeps that anode dark; slot timing is unchanged
    assign w_anodo_dez = (r_n[7:4] == 4'h0) ? 2'b11 : 2'b01;
`else
    assign w_anodo_dez = 2'b01;
`endif

    // Shadow register: holds the most recent score until the next frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sombra <= 8'h00;
        end else if (atualiza) begin
            r_sombra <= placar;
        end
    end

    // Scan FSM with slot counter; all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado  <= IDLE;
            r_cnt     <= '0;
            r_n       <= 8'h00;
            r_escolha <= 1'b0;
            r_anodo   <= 2'b11;
            r_quadro  <= 1'b0;
        end else if (!habilita) begin
            r_estado  <= IDLE;
            r_cnt     <= '0;
            r_escolha <= 1'b0;
            r_anodo   <= 2'b11;
            r_quadro  <= 1'b0;
        end else begin
            r_quadro <= 1'b0;
            case (r_estado)
                IDLE: begin
                    // Frame start: latch the display value and light units
                    r_estado  <= UNID;
                    r_cnt     <= '0;
                    r_n       <= w_carga;
                    r_escolha <= 1'b0;
                    r_anodo   <= 2'b10;
                    r_quadro  <= 1'b1;
                end
                UNID: begin
                    if (w_fim_div) begin
                        r_cnt <= '0;
                        if (BLANK > 0) begin
                            r_estado  <= PAUSA_U;
                            r_escolha <= 1'b0;
                            r_anodo   <= 2'b11;
                        end else begin
                            r_estado  <= DEZ;
                            r_escolha <= 1'b1;
                            r_anodo   <= w_anodo_dez;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PAUSA_U: begin
                    if (w_fim_blk) begin
                        r_cnt     <= '0;
                        r_estado  <= DEZ;
                        r_escolha <= 1'b1;
                        r_anodo   <= w_anodo_dez;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DEZ: begin
                    if (w_fim_div) begin
                        r_cnt <= '0;
                        if (BLANK > 0) begin
                            r_estado  <= PAUSA_D;
                            r_escolha <= 1'b1;
                            r_anodo   <= 2'b11;
                        end else begin
                            r_estado  <= UNID;
                            r_n       <= w_carga;
                            r_escolha <= 1'b0;
                            r_anodo   <= 2'b10;
                            r_quadro  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PAUSA_D: begin
                    if (w_fim_blk) begin
                        r_cnt     <= '0;
                        r_estado  <= UNID;
                        r_n       <= w_carga;
                        r_escolha <= 1'b0;
                        r_anodo   <= 2'b10;
                        r_quadro  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_estado  <= IDLE;
                    r_cnt     <= '0;
                    r_escolha <= 1'b0;
                    r_anodo   <= 2'b11;
                end
            endcase
        end
    end

    assign N       = r_n;
    assign escolha = r_escolha;
    assign anodo   = r_anodo;
    assign quadro  = r_quadro;

endmodule
